// File: rtl/tt_um_acumulador.sv
// tt_um_acumulador: byte-serial accumulator (ADD/SUB/CLR/LOAD) with selectable output byte.
// Ports:
//   clk      - clock, all state on rising edge
//   rst_n    - asynchronous active-low reset
//   ena      - design enable; strobes ignored while low, aborts a partial operand
//   ui_in    - operand data byte
//   uio_in   - [0]=stb, [2:1]=op (00 ADD, 01 SUB, 10 CLR, 11 LOAD), [3]=sel
//   uo_out   - accumulator byte selected by bsel
//   uio_out  - [4]=carry/borrow, [5]=signed overflow, [6]=zero, [7]=busy
//   uio_oe   - constant 8'hF0
// Optional feature: define SUM_SAT_EN for unsigned saturation of ADD/SUB.
module tt_um_acumulador #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int NBYTES = WIDTH / 8;
  localparam logic [1:0] LAST = 2'(NBYTES - 1);
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CLR = 2'b10, OP_LOAD = 2'b11;
  typedef enum logic [1:0] {IDLE, COLLECT, EXEC} state_t;
  state_t           state_q, state_d;
  logic [2:0]       stb_q, sel_q;
  logic [1:0]       op_q, op_d, cnt_q, cnt_d, bsel_q, bsel_d;
  logic [WIDTH-1:0] acc_q, acc_d, opnd_q, opnd_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [WIDTH:0]   sum, dif;
  logic             stb_p, sel_p, unused_hi;
  // [1:0] are the two synchroniser flops, [2] holds the previous synchronised value
  assign stb_p = ena & stb_q[1] & ~stb_q[2];
  assign sel_p = ena & sel_q[1] & ~sel_q[2];
  assign unused_hi = &uio_in[7:4];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    sum     = {1'b0, acc_q} + {1'b0, opnd_q};
    dif     = {1'b0, acc_q} - {1'b0, opnd_q};
    bsel_d  = sel_p ? (bsel_q == LAST ? 2'd0 : bsel_q + 2'd1) : bsel_q;
    case (state_q)
      IDLE: if (stb_p) begin
        op_d = uio_in[2:1];
        if (uio_in[2:1] == OP_CLR) state_d = EXEC;
        else begin
          opnd_d  = WIDTH'(ui_in);
          cnt_d   = 2'd1;
          state_d = NBYTES == 1 ? EXEC : COLLECT;
        end
      end
      COLLECT: if (!ena) begin
        state_d = IDLE;
        cnt_d   = 2'd0;
        opnd_d  = '0;
      end else if (stb_p) begin
        for (int i = 0; i < NBYTES; i++) if (cnt_q == 2'(i)) opnd_d[8*i +: 8] = ui_in;
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == LAST ? EXEC : COLLECT;
      end
      EXEC: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
        case (op_q)
          OP_ADD: begin
            acc_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            ovf_d   = (acc_q[WIDTH-1] ^ sum[WIDTH-1]) & (opnd_q[WIDTH-1] ^ sum[WIDTH-1]);
`ifdef SUM_SAT_EN
            if (sum[WIDTH]) acc_d = '1;
`endif
          end
          OP_SUB: begin
            acc_d   = dif[WIDTH-1:0];
            carry_d = dif[WIDTH];
            ovf_d   = (acc_q[WIDTH-1] ^ opnd_q[WIDTH-1]) & (acc_q[WIDTH-1] ^ dif[WIDTH-1]);
`ifdef SUM_SAT_EN
            if (dif[WIDTH]) acc_d = '0;
`endif
          end
          OP_CLR: begin
            acc_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          OP_LOAD: begin
            acc_d   = opnd_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
        endcase
        zero_d = acc_d == '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stb_q   <= '0;
      sel_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      bsel_q  <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      stb_q   <= {stb_q[1:0], uio_in[0]};
      sel_q   <= {sel_q[1:0], uio_in[3]};
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      bsel_q  <= bsel_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  always_comb begin
    uo_out = 8'h00;
    for (int i = 0; i < NBYTES; i++) if (bsel_q == 2'(i)) uo_out = acc_q[8*i +: 8];
  end
  assign uio_out = {state_q != IDLE, zero_q, ovf_q, carry_q, 4'b0000};
  assign uio_oe  = 8'hF0;
endmodule
